// File: rtl/ptw_mem_arbiter.sv
// Round-robin arbiter sharing one AXI read port between the iTLB and dTLB page-table walkers.
// Optional WAIT-state timeout enabled by defining PTW_ARB_TIMEOUT_EN.
module ptw_mem_arbiter #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  R0_ADDR_VALID,
   input  logic [ADDR_WIDTH-1:0] R0_ADDR,
   output logic                  R0_DATA_VALID,
   output logic [DATA_WIDTH-1:0] R0_DATA,
   output logic                  R0_ERR,
   input  logic                  R1_ADDR_VALID,
   input  logic [ADDR_WIDTH-1:0] R1_ADDR,
   output logic                  R1_DATA_VALID,
   output logic [DATA_WIDTH-1:0] R1_DATA,
   output logic                  R1_ERR,
   output logic                  M_ADDR_VALID,
   output logic [ADDR_WIDTH-1:0] M_ADDR,
   input  logic                  M_ADDR_READY,
   input  logic                  M_DATA_VALID,
   input  logic [DATA_WIDTH-1:0] M_DATA
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT
   } state_t;

   state_t                state_q, state_d;
   logic                  pend0_q, pend0_d;
   logic                  pend1_q, pend1_d;
   logic [ADDR_WIDTH-1:0] addr0_q, addr0_d;
   logic [ADDR_WIDTH-1:0] addr1_q, addr1_d;
   logic                  last_grant_q, last_grant_d;
   logic                  owner_q, owner_d;
   logic                  m_addr_valid_q, m_addr_valid_d;
   logic [ADDR_WIDTH-1:0] m_addr_q, m_addr_d;
   logic                  r0_dv_q, r0_dv_d;
   logic [DATA_WIDTH-1:0] r0_data_q, r0_data_d;
   logic                  r0_err_q, r0_err_d;
   logic                  r1_dv_q, r1_dv_d;
   logic [DATA_WIDTH-1:0] r1_data_q, r1_data_d;
   logic                  r1_err_q, r1_err_d;

   logic                  timeout_hit;
   logic                  done;
   logic                  busy0;
   logic                  busy1;
   logic                  accept0;
   logic                  accept1;
   logic                  winner;

`ifdef PTW_ARB_TIMEOUT_EN
   logic [31:0]           cnt_q, cnt_d;

   assign timeout_hit = (state_q == ST_WAIT) && (cnt_q == 32'(TIMEOUT_CYCLES - 1));
`else
   assign timeout_hit = 1'b0;
`endif

   // A requester whose walk finishes on this edge may already queue its next one.
   assign done    = (state_q == ST_WAIT) && (M_DATA_VALID || timeout_hit);
   assign busy0   = (state_q != ST_IDLE) && (owner_q == 1'b0) && !done;
   assign busy1   = (state_q != ST_IDLE) && (owner_q == 1'b1) && !done;
   assign accept0 = R0_ADDR_VALID && !pend0_q && !busy0;
   assign accept1 = R1_ADDR_VALID && !pend1_q && !busy1;

   always_comb begin
      state_d        = state_q;
      pend0_d        = pend0_q;
      pend1_d        = pend1_q;
      addr0_d        = addr0_q;
      addr1_d        = addr1_q;
      last_grant_d   = last_grant_q;
      owner_d        = owner_q;
      m_addr_valid_d = m_addr_valid_q;
      m_addr_d       = m_addr_q;
      r0_dv_d        = 1'b0;
      r0_data_d      = r0_data_q;
      r0_err_d       = 1'b0;
      r1_dv_d        = 1'b0;
      r1_data_d      = r1_data_q;
      r1_err_d       = 1'b0;
      winner         = 1'b0;
`ifdef PTW_ARB_TIMEOUT_EN
      cnt_d          = cnt_q;
`endif

      case (state_q)
         ST_IDLE: begin
            if (pend0_q || pend1_q) begin
               // On a tie the requester not served last time wins.
               winner         = (pend0_q && pend1_q) ? ~last_grant_q : pend1_q;
               m_addr_valid_d = 1'b1;
               m_addr_d       = winner ? addr1_q : addr0_q;
               if (winner) begin
                  pend1_d = 1'b0;
               end else begin
                  pend0_d = 1'b0;
               end
               last_grant_d = winner;
               owner_d      = winner;
               state_d      = ST_ISSUE;
            end
         end

         ST_ISSUE: begin
            if (M_ADDR_READY) begin
               m_addr_valid_d = 1'b0;
               state_d        = ST_WAIT;
`ifdef PTW_ARB_TIMEOUT_EN
               cnt_d          = 32'd0;
`endif
            end
         end

         ST_WAIT: begin
            if (M_DATA_VALID) begin
               if (owner_q) begin
                  r1_dv_d   = 1'b1;
                  r1_data_d = M_DATA;
               end else begin
                  r0_dv_d   = 1'b1;
                  r0_data_d = M_DATA;
               end
               state_d = ST_IDLE;
            end
`ifdef PTW_ARB_TIMEOUT_EN
            else if (timeout_hit) begin
               if (owner_q) begin
                  r1_err_d = 1'b1;
               end else begin
                  r0_err_d = 1'b1;
               end
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
`endif
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (accept0) begin
         pend0_d = 1'b1;
         addr0_d = R0_ADDR;
      end
      if (accept1) begin
         pend1_d = 1'b1;
         addr1_d = R1_ADDR;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q        <= ST_IDLE;
         pend0_q        <= 1'b0;
         pend1_q        <= 1'b0;
         addr0_q        <= '0;
         addr1_q        <= '0;
         last_grant_q   <= 1'b1;
         owner_q        <= 1'b0;
         m_addr_valid_q <= 1'b0;
         m_addr_q       <= '0;
         r0_dv_q        <= 1'b0;
         r0_data_q      <= '0;
         r0_err_q       <= 1'b0;
         r1_dv_q        <= 1'b0;
         r1_data_q      <= '0;
         r1_err_q       <= 1'b0;
      end else begin
         state_q        <= state_d;
         pend0_q        <= pend0_d;
         pend1_q        <= pend1_d;
         addr0_q        <= addr0_d;
         addr1_q        <= addr1_d;
         last_grant_q   <= last_grant_d;
         owner_q        <= owner_d;
         m_addr_valid_q <= m_addr_valid_d;
         m_addr_q       <= m_addr_d;
         r0_dv_q        <= r0_dv_d;
         r0_data_q      <= r0_data_d;
         r0_err_q       <= r0_err_d;
         r1_dv_q        <= r1_dv_d;
         r1_data_q      <= r1_data_d;
         r1_err_q       <= r1_err_d;
      end
   end

`ifdef PTW_ARB_TIMEOUT_EN
   always_ff @(posedge CLK) begin
      if (RST) begin
         cnt_q <= 32'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`endif

   assign R0_DATA_VALID = r0_dv_q;
   assign R0_DATA       = r0_data_q;
   assign R0_ERR        = r0_err_q;
   assign R1_DATA_VALID = r1_dv_q;
   assign R1_DATA       = r1_data_q;
   assign R1_ERR        = r1_err_q;
   assign M_ADDR_VALID  = m_addr_valid_q;
   assign M_ADDR        = m_addr_q;

endmodule

// File: tb/tb_ptw_mem_arbiter.sv
// Directed vector bench for ptw_mem_arbiter: a per-cycle vector table plus hand-written
// sequences for fairness, ISSUE stall, reset in WAIT and the WAIT timeout.
module tb_ptw_mem_arbiter;

   logic        CLK = 1'b0;
   logic        RST;
   logic        R0_ADDR_VALID;
   logic [31:0] R0_ADDR;
   logic        R0_DATA_VALID;
   logic [31:0] R0_DATA;
   logic        R0_ERR;
   logic        R1_ADDR_VALID;
   logic [31:0] R1_ADDR;
   logic        R1_DATA_VALID;
   logic [31:0] R1_DATA;
   logic        R1_ERR;
   logic        M_ADDR_VALID;
   logic [31:0] M_ADDR;
   logic        M_ADDR_READY;
   logic        M_DATA_VALID;
   logic [31:0] M_DATA;

   int vec_count  = 0;
   int miss_count = 0;

   typedef struct {
      logic        rst;
      logic        r0v;
      logic [31:0] r0a;
      logic        r1v;
      logic [31:0] r1a;
      logic        rdy;
      logic        mdv;
      logic [31:0] md;
      logic        e_mav;
      logic [31:0] e_ma;
      logic        e_r0dv;
      logic [31:0] e_r0d;
      logic        e_r1dv;
      logic [31:0] e_r1d;
   } vec_t;

   vec_t vecs[$];

   ptw_mem_arbiter #(
      .ADDR_WIDTH    (32),
      .DATA_WIDTH    (32),
      .TIMEOUT_CYCLES(16)
   ) dut (
      .CLK          (CLK),
      .RST          (RST),
      .R0_ADDR_VALID(R0_ADDR_VALID),
      .R0_ADDR      (R0_ADDR),
      .R0_DATA_VALID(R0_DATA_VALID),
      .R0_DATA      (R0_DATA),
      .R0_ERR       (R0_ERR),
      .R1_ADDR_VALID(R1_ADDR_VALID),
      .R1_ADDR      (R1_ADDR),
      .R1_DATA_VALID(R1_DATA_VALID),
      .R1_DATA      (R1_DATA),
      .R1_ERR       (R1_ERR),
      .M_ADDR_VALID (M_ADDR_VALID),
      .M_ADDR       (M_ADDR),
      .M_ADDR_READY (M_ADDR_READY),
      .M_DATA_VALID (M_DATA_VALID),
      .M_DATA       (M_DATA)
   );

   always #5 CLK = ~CLK;

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      vec_count++;
      if (act !== exp) begin
         miss_count++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic idle_inputs();
      RST           = 1'b0;
      R0_ADDR_VALID = 1'b0;
      R1_ADDR_VALID = 1'b0;
      M_ADDR_READY  = 1'b0;
      M_DATA_VALID  = 1'b0;
   endtask

   task automatic reset_dut();
      idle_inputs();
      RST = 1'b1;
      step();
      RST = 1'b0;
   endtask

   task automatic applyStimulus(input vec_t v);
      RST           = v.rst;
      R0_ADDR_VALID = v.r0v;
      R0_ADDR       = v.r0a;
      R1_ADDR_VALID = v.r1v;
      R1_ADDR       = v.r1a;
      M_ADDR_READY  = v.rdy;
      M_DATA_VALID  = v.mdv;
      M_DATA        = v.md;
      step();
   endtask

   task automatic add_vec(input logic rst, input logic r0v, input logic [31:0] r0a,
                          input logic r1v, input logic [31:0] r1a, input logic rdy,
                          input logic mdv, input logic [31:0] md, input logic e_mav,
                          input logic [31:0] e_ma, input logic e_r0dv, input logic [31:0] e_r0d,
                          input logic e_r1dv, input logic [31:0] e_r1d);
      vec_t v;
      v.rst = rst; v.r0v = r0v; v.r0a = r0a; v.r1v = r1v; v.r1a = r1a;
      v.rdy = rdy; v.mdv = mdv; v.md = md;
      v.e_mav = e_mav; v.e_ma = e_ma; v.e_r0dv = e_r0dv; v.e_r0d = e_r0d;
      v.e_r1dv = e_r1dv; v.e_r1d = e_r1d;
      vecs.push_back(v);
   endtask

   task automatic check_all_zero(input string tag);
      checkOutput({tag, "_mav"},  32'(M_ADDR_VALID), 0);
      checkOutput({tag, "_ma"},   M_ADDR, 0);
      checkOutput({tag, "_r0dv"}, 32'(R0_DATA_VALID), 0);
      checkOutput({tag, "_r0d"},  R0_DATA, 0);
      checkOutput({tag, "_r1dv"}, 32'(R1_DATA_VALID), 0);
      checkOutput({tag, "_r1d"},  R1_DATA, 0);
      checkOutput({tag, "_r0err"}, 32'(R0_ERR), 0);
      checkOutput({tag, "_r1err"}, 32'(R1_ERR), 0);
   endtask

   initial begin
      bit exp_owner;
      int waited;

      idle_inputs();
      R0_ADDR = '0;
      R1_ADDR = '0;
      M_DATA  = '0;

      //       rst r0v r0a         r1v r1a         rdy mdv md            mav ma          r0dv r0d           r1dv r1d
      add_vec(1, 0, 0,           0, 0,           0, 0, 0,            0, 0,           0, 0,            0, 0);
      add_vec(0, 0, 0,           0, 0,           0, 1, 32'hDEAD,     0, 0,           0, 0,            0, 0);
      add_vec(0, 1, 32'h1000,    0, 0,           0, 0, 0,            0, 0,           0, 0,            0, 0);
      add_vec(0, 0, 0,           0, 0,           0, 0, 0,            1, 32'h1000,    0, 0,            0, 0);
      add_vec(0, 0, 0,           0, 0,           1, 0, 0,            0, 32'h1000,    0, 0,            0, 0);
      add_vec(0, 0, 0,           0, 0,           0, 0, 0,            0, 32'h1000,    0, 0,            0, 0);
      add_vec(0, 0, 0,           0, 0,           0, 0, 0,            0, 32'h1000,    0, 0,            0, 0);
      add_vec(0, 0, 0,           0, 0,           0, 1, 32'hCAFE0001, 0, 32'h1000,    1, 32'hCAFE0001, 0, 0);
      add_vec(0, 0, 0,           0, 0,           0, 0, 0,            0, 32'h1000,    0, 32'hCAFE0001, 0, 0);
      add_vec(1, 0, 0,           0, 0,           0, 0, 0,            0, 0,           0, 0,            0, 0);
      add_vec(0, 1, 32'h2000,    1, 32'h3000,    0, 0, 0,            0, 0,           0, 0,            0, 0);
      add_vec(0, 0, 0,           0, 0,           0, 0, 0,            1, 32'h2000,    0, 0,            0, 0);
      add_vec(0, 0, 0,           0, 0,           1, 0, 0,            0, 32'h2000,    0, 0,            0, 0);
      add_vec(0, 0, 0,           0, 0,           0, 1, 32'hD0D00002, 0, 32'h2000,    1, 32'hD0D00002, 0, 0);
      add_vec(0, 0, 0,           0, 0,           0, 0, 0,            1, 32'h3000,    0, 32'hD0D00002, 0, 0);
      add_vec(0, 0, 0,           0, 0,           1, 0, 0,            0, 32'h3000,    0, 32'hD0D00002, 0, 0);
      add_vec(0, 0, 0,           0, 0,           0, 1, 32'hD1D10003, 0, 32'h3000,    0, 32'hD0D00002, 1, 32'hD1D10003);
      add_vec(0, 0, 0,           1, 32'h4000,    0, 0, 0,            0, 32'h3000,    0, 32'hD0D00002, 0, 32'hD1D10003);
      add_vec(0, 0, 0,           0, 0,           0, 0, 0,            1, 32'h4000,    0, 32'hD0D00002, 0, 32'hD1D10003);
      add_vec(0, 0, 0,           0, 0,           1, 0, 0,            0, 32'h4000,    0, 32'hD0D00002, 0, 32'hD1D10003);
      add_vec(0, 0, 0,           1, 32'h5000,    0, 1, 32'h44440004, 0, 32'h4000,    0, 32'hD0D00002, 1, 32'h44440004);
      add_vec(0, 0, 0,           0, 0,           0, 0, 0,            1, 32'h5000,    0, 32'hD0D00002, 0, 32'h44440004);
      add_vec(0, 0, 0,           0, 0,           1, 0, 0,            0, 32'h5000,    0, 32'hD0D00002, 0, 32'h44440004);
      add_vec(0, 0, 0,           0, 0,           0, 1, 32'h55550005, 0, 32'h5000,    0, 32'hD0D00002, 1, 32'h55550005);
      add_vec(0, 0, 0,           0, 0,           0, 0, 0,            0, 32'h5000,    0, 32'hD0D00002, 0, 32'h55550005);

      foreach (vecs[i]) begin
         applyStimulus(vecs[i]);
         checkOutput($sformatf("v%0d_mav", i),  32'(M_ADDR_VALID),  32'(vecs[i].e_mav));
         checkOutput($sformatf("v%0d_ma", i),   M_ADDR,             vecs[i].e_ma);
         checkOutput($sformatf("v%0d_r0dv", i), 32'(R0_DATA_VALID), 32'(vecs[i].e_r0dv));
         checkOutput($sformatf("v%0d_r0d", i),  R0_DATA,            vecs[i].e_r0d);
         checkOutput($sformatf("v%0d_r1dv", i), 32'(R1_DATA_VALID), 32'(vecs[i].e_r1dv));
         checkOutput($sformatf("v%0d_r1d", i),  R1_DATA,            vecs[i].e_r1d);
         checkOutput($sformatf("v%0d_err", i),  {30'd0, R1_ERR, R0_ERR}, 0);
      end
      idle_inputs();

      // Both walkers re-request on every response; grants must alternate starting with R0.
      reset_dut();
      R0_ADDR = 32'hA000;
      R1_ADDR = 32'hB000;
      R0_ADDR_VALID = 1'b1;
      R1_ADDR_VALID = 1'b1;
      step();
      idle_inputs();
      exp_owner = 1'b0;
      for (int round = 0; round < 8; round++) begin
         waited = 0;
         while (!M_ADDR_VALID && waited < 10) begin
            step();
            waited++;
         end
         checkOutput("fair_grant_seen", 32'(M_ADDR_VALID), 1);
         checkOutput($sformatf("fair_owner_r%0d", round), M_ADDR, exp_owner ? 32'hB000 : 32'hA000);
         M_ADDR_READY = 1'b1;
         step();
         M_ADDR_READY = 1'b0;
         M_DATA_VALID = 1'b1;
         M_DATA = 32'hF000 + 32'(round);
         if (exp_owner) R1_ADDR_VALID = 1'b1;
         else           R0_ADDR_VALID = 1'b1;
         step();
         idle_inputs();
         checkOutput("fair_dv_owner", 32'(exp_owner ? R1_DATA_VALID : R0_DATA_VALID), 1);
         checkOutput("fair_dv_other", 32'(exp_owner ? R0_DATA_VALID : R1_DATA_VALID), 0);
         checkOutput("fair_data", exp_owner ? R1_DATA : R0_DATA, 32'hF000 + 32'(round));
         exp_owner = !exp_owner;
      end

      // ISSUE stall with a stray data pulse that must be ignored.
      reset_dut();
      R0_ADDR = 32'h6000;
      R0_ADDR_VALID = 1'b1;
      step();
      idle_inputs();
      step();
      checkOutput("stall_mav_start", 32'(M_ADDR_VALID), 1);
      for (int i = 0; i < 5; i++) begin
         M_DATA_VALID = (i == 2);
         M_DATA = 32'h99;
         step();
         checkOutput("stall_mav", 32'(M_ADDR_VALID), 1);
         checkOutput("stall_ma", M_ADDR, 32'h6000);
         checkOutput("stall_dv", {30'd0, R1_DATA_VALID, R0_DATA_VALID}, 0);
      end
      M_DATA_VALID = 1'b0;
      M_ADDR_READY = 1'b1;
      step();
      M_ADDR_READY = 1'b0;
      checkOutput("stall_mav_drop", 32'(M_ADDR_VALID), 0);
      M_DATA_VALID = 1'b1;
      M_DATA = 32'h66660006;
      step();
      idle_inputs();
      checkOutput("stall_r0dv", 32'(R0_DATA_VALID), 1);
      checkOutput("stall_r0d", R0_DATA, 32'h66660006);

      // Reset while in WAIT, then a stale response and a fresh request.
      reset_dut();
      R1_ADDR = 32'h7000;
      R1_ADDR_VALID = 1'b1;
      step();
      idle_inputs();
      step();
      M_ADDR_READY = 1'b1;
      step();
      idle_inputs();
      RST = 1'b1;
      step();
      RST = 1'b0;
      check_all_zero("rstwait");
      M_DATA_VALID = 1'b1;
      M_DATA = 32'hBADBAD00;
      step();
      idle_inputs();
      check_all_zero("stale");
      R0_ADDR = 32'h8000;
      R0_ADDR_VALID = 1'b1;
      step();
      idle_inputs();
      step();
      checkOutput("post_rst_mav", 32'(M_ADDR_VALID), 1);
      checkOutput("post_rst_ma", M_ADDR, 32'h8000);
      M_ADDR_READY = 1'b1;
      step();
      idle_inputs();
      M_DATA_VALID = 1'b1;
      M_DATA = 32'h88880008;
      step();
      idle_inputs();
      checkOutput("post_rst_r0dv", 32'(R0_DATA_VALID), 1);
      checkOutput("post_rst_r0d", R0_DATA, 32'h88880008);

      // R1 never answered; R0 queues behind it during WAIT.
      reset_dut();
      R1_ADDR = 32'h9000;
      R1_ADDR_VALID = 1'b1;
      step();
      idle_inputs();
      step();
      M_ADDR_READY = 1'b1;
      step();
      idle_inputs();
      R0_ADDR = 32'hA5A0;
      R0_ADDR_VALID = 1'b1;
`ifdef PTW_ARB_TIMEOUT_EN
      for (int i = 1; i <= 16; i++) begin
         step();
         R0_ADDR_VALID = 1'b0;
         if (i < 16) checkOutput($sformatf("to_early_%0d", i), 32'(R1_ERR), 0);
      end
      checkOutput("to_r1err", 32'(R1_ERR), 1);
      checkOutput("to_r0err", 32'(R0_ERR), 0);
      checkOutput("to_r1dv", 32'(R1_DATA_VALID), 0);
      step();
      checkOutput("to_r1err_pulse", 32'(R1_ERR), 0);
      checkOutput("to_r0_grant_mav", 32'(M_ADDR_VALID), 1);
      checkOutput("to_r0_grant_ma", M_ADDR, 32'hA5A0);
`else
      for (int i = 1; i <= 40; i++) begin
         step();
         R0_ADDR_VALID = 1'b0;
      end
      checkOutput("nto_mav", 32'(M_ADDR_VALID), 0);
      checkOutput("nto_err", {30'd0, R1_ERR, R0_ERR}, 0);
      checkOutput("nto_dv", {30'd0, R1_DATA_VALID, R0_DATA_VALID}, 0);
      M_DATA_VALID = 1'b1;
      M_DATA = 32'h99990009;
      step();
      idle_inputs();
      checkOutput("nto_r1dv", 32'(R1_DATA_VALID), 1);
      checkOutput("nto_r1d", R1_DATA, 32'h99990009);
      step();
      checkOutput("nto_r0_grant_mav", 32'(M_ADDR_VALID), 1);
      checkOutput("nto_r0_grant_ma", M_ADDR, 32'hA5A0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
      $finish;
   end

endmodule
